dmem_responder: RTL and testbench

- Data-memory responder at the far end of the execute/memory-stage data-access interface.
- Consumes the pipeline's active-low request (DREQ) and read/write select (DRW), and services one word access with a fixed number of wait states.
- Returns read data with a one-cycle completion pulse.
- Drives a stall to the pipeline registers while an access is outstanding; acts as the system's word-addressed data RAM.

---
 rtl/dmem_responder.sv | 106 ++++++++++
 tb/tb_dmem_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data RAM answering the pipeline's
// active-low access request after a fixed number of wait states.
// STALL holds upstream pipeline registers while an access is in flight.
// DVALID pulses for one cycle when an access completes. DRDATA keeps the
// data of the last completed read.
module dmem_responder #(
   parameter int ADDR_W = 10,
   parameter int LAT    = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        DREQ,
   input  logic        DRW,
   input  logic [31:0] DADDR,
   input  logic [31:0] DWDATA,
   output logic [31:0] DRDATA,
   output logic        DVALID,
   output logic        STALL
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   // The counter is loaded on acceptance. WAIT leaves for DONE once the
   // counter has counted down to 1.
   localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

   state_t              state;
   logic [3:0]          cnt;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         wdata_q;
   logic                rw_q;

   logic [31:0]         mem [0:(1<<ADDR_W)-1];

   logic [ADDR_W-1:0]   req_addr;
   logic                accept;
   logic                to_done;
   logic [ADDR_W-1:0]   rd_addr;
   logic                rd_rw;
   logic                unused_addr_bits;

   // Word select only. Upper bits alias modulo depth, and the byte offset
   // is dropped because there are no byte enables.
   assign req_addr         = DADDR[ADDR_W+1:2];
   assign unused_addr_bits = ^{DADDR[31:ADDR_W+2], DADDR[1:0]};

   assign accept  = (state == IDLE) && !DREQ;
   assign to_done = (accept && (LAT == 1)) || ((state == WAIT) && (cnt == 4'd1));

   // With LAT=1, DONE is entered directly from IDLE. In that case the read
   // has to use the live request instead of the latched copy.
   assign rd_addr = (state == IDLE) ? req_addr : addr_q;
   assign rd_rw   = (state == IDLE) ? DRW      : rw_q;

   // Stall covers the acceptance cycle and every wait cycle. It is released
   // in DONE so the pipeline advances on the edge that ends DONE.
   // A request seen while reset is asserted does not stall the pipeline.
   assign STALL = !RST && (accept || (state == WAIT));

   // Access sequencer: latches the request, counts wait states, and
   // registers the completion pulse and the read data on entry to DONE.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= IDLE;
         cnt     <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rw_q    <= 1'b0;
         DRDATA  <= '0;
         DVALID  <= 1'b0;
      end else begin
         DVALID <= to_done;
         if (to_done && !rd_rw)
            DRDATA <= mem[rd_addr];
         case (state)
            IDLE: begin
               if (!DREQ) begin
                  addr_q  <= req_addr;
                  wdata_q <= DWDATA;
                  rw_q    <= DRW;
                  cnt     <= CNT_INIT;
                  state   <= (LAT == 1) ? DONE : WAIT;
               end
            end
            WAIT: begin
               if (cnt == 4'd1) begin
                  cnt   <= '0;
                  state <= DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Write commit happens on the edge that ends DONE. Reset forces the
   // state to IDLE asynchronously, so an aborted write never lands.
   always_ff @(posedge CLK) begin
      if ((state == DONE) && rw_q)
         mem[addr_q] <= wdata_q;
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder. It uses four instances with LAT = 2, 1, 4
// and 3. Completions are checked against a scoreboard queue.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst    [4];
   logic        dreq   [4];
   logic        drw    [4];
   logic [31:0] daddr  [4];
   logic [31:0] dwdata [4];
   logic [31:0] drdata [4];
   logic        dvalid [4];
   logic        stall  [4];

   int pass_cnt = 0;
   int total    = 0;
   int pulses   = 0;
   int accesses = 0;

   typedef struct {
      int          inst;
      bit          rw;
      logic [31:0] data;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      int          inst;
      bit          rw;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[$];

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_W(10), .LAT(2)) u0 (
      .CLK(clk), .RST(rst[0]), .DREQ(dreq[0]), .DRW(drw[0]), .DADDR(daddr[0]),
      .DWDATA(dwdata[0]), .DRDATA(drdata[0]), .DVALID(dvalid[0]), .STALL(stall[0]));
   dmem_responder #(.ADDR_W(10), .LAT(1)) u1 (
      .CLK(clk), .RST(rst[1]), .DREQ(dreq[1]), .DRW(drw[1]), .DADDR(daddr[1]),
      .DWDATA(dwdata[1]), .DRDATA(drdata[1]), .DVALID(dvalid[1]), .STALL(stall[1]));
   dmem_responder #(.ADDR_W(10), .LAT(4)) u2 (
      .CLK(clk), .RST(rst[2]), .DREQ(dreq[2]), .DRW(drw[2]), .DADDR(daddr[2]),
      .DWDATA(dwdata[2]), .DRDATA(drdata[2]), .DVALID(dvalid[2]), .STALL(stall[2]));
   dmem_responder #(.ADDR_W(10), .LAT(3)) u3 (
      .CLK(clk), .RST(rst[3]), .DREQ(dreq[3]), .DRW(drw[3]), .DADDR(daddr[3]),
      .DWDATA(dwdata[3]), .DRDATA(drdata[3]), .DVALID(dvalid[3]), .STALL(stall[3]));

   function automatic int lat_of(input int i);
      return (i == 0) ? 2 : (i == 1) ? 1 : (i == 2) ? 4 : 3;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Every completion pulse must match the oldest outstanding access.
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (dvalid[i] === 1'b1) begin
            pulses++;
            if (sb_q.size() == 0 || sb_q[0].inst != i) begin
               check($sformatf("unexpected_pulse_inst%0d", i), 32'd1, 32'd0);
            end else begin
               if (!sb_q[0].rw)
                  check($sformatf("rdata_inst%0d", i), drdata[i], sb_q[0].data);
               void'(sb_q.pop_front());
            end
         end
      end
   end

   // Entry: just after a rising edge, with the instance in IDLE.
   // Exit: just after the edge that ends DONE.
   task automatic do_access(input int i, input bit rw, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp);
      int lat;
      sb_t e;
      lat    = lat_of(i);
      e.inst = i; e.rw = rw; e.data = exp;
      sb_q.push_back(e);
      accesses++;
      dreq[i] = 1'b0; drw[i] = rw; daddr[i] = addr; dwdata[i] = wdata;
      for (int c = 0; c < lat; c++) begin
         @(negedge clk);
         check($sformatf("stall_hi_inst%0d_c%0d", i, c), {31'd0, stall[i]}, 32'd1);
         check($sformatf("dvalid_lo_inst%0d_c%0d", i, c), {31'd0, dvalid[i]}, 32'd0);
         @(posedge clk); #1;
         if (c == 0) begin
            // The responder must work from its latched copy from here on.
            dreq[i] = 1'b1; daddr[i] = addr + 32'd4; dwdata[i] = 32'd0;
         end
      end
      @(negedge clk);
      check($sformatf("stall_done_inst%0d", i), {31'd0, stall[i]}, 32'd0);
      check($sformatf("dvalid_done_inst%0d", i), {31'd0, dvalid[i]}, 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         rst[i] = 1'b1; dreq[i] = 1'b1; drw[i] = 1'b0; daddr[i] = '0; dwdata[i] = '0;
      end
      dreq[0] = 1'b0;
      #3;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rst_drdata_%0d", i), drdata[i], 32'd0);
         check($sformatf("rst_dvalid_%0d", i), {31'd0, dvalid[i]}, 32'd0);
      end
      check("rst_stall_with_req", {31'd0, stall[0]}, 32'd0);
      dreq[0] = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) rst[i] = 1'b0;
      @(posedge clk); #1;

      // inst, rw, addr, wdata, expected read data
      vecs.push_back('{0, 1'b1, 32'h10,   32'hDEADBEEF, 32'h0});
      vecs.push_back('{0, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF});
      vecs.push_back('{0, 1'b1, 32'h1004, 32'h11111111, 32'h0});
      vecs.push_back('{0, 1'b0, 32'h0004, 32'h0,        32'h11111111});
      vecs.push_back('{0, 1'b0, 32'h0007, 32'h0,        32'h11111111});
      vecs.push_back('{0, 1'b1, 32'h3FFC, 32'h5A5A5A5A, 32'h0});
      vecs.push_back('{0, 1'b0, 32'h0FFC, 32'h0,        32'h5A5A5A5A});
      vecs.push_back('{1, 1'b1, 32'hC,    32'h12345678, 32'h0});
      vecs.push_back('{1, 1'b0, 32'hC,    32'h0,        32'h12345678});
      vecs.push_back('{2, 1'b1, 32'h24,   32'h99999999, 32'h0});
      vecs.push_back('{2, 1'b1, 32'h20,   32'hAAAA5555, 32'h0});
      vecs.push_back('{2, 1'b0, 32'h20,   32'h0,        32'hAAAA5555});
      vecs.push_back('{2, 1'b0, 32'h24,   32'h0,        32'h99999999});
      vecs.push_back('{3, 1'b1, 32'h50,   32'h0BADF00D, 32'h0});
      vecs.push_back('{3, 1'b0, 32'h50,   32'h0,        32'h0BADF00D});
      foreach (vecs[k])
         do_access(vecs[k].inst, vecs[k].rw, vecs[k].addr, vecs[k].wdata, vecs[k].exp);

      // A write completing must not disturb the held read data.
      do_access(0, 1'b1, 32'h30, 32'hCAFEF00D, 32'h0);
      do_access(0, 1'b0, 32'h30, 32'h0, 32'hCAFEF00D);
      do_access(0, 1'b1, 32'h40, 32'h12121212, 32'h0);
      check("hold_after_write", drdata[0], 32'hCAFEF00D);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check($sformatf("idle_dvalid_%0d", c), {31'd0, dvalid[0]}, 32'd0);
         check($sformatf("idle_hold_%0d", c), drdata[0], 32'hCAFEF00D);
      end
      @(posedge clk); #1;

      // Reset in the first WAIT cycle after a write is accepted.
      dreq[3] = 1'b0; drw[3] = 1'b1; daddr[3] = 32'h50; dwdata[3] = 32'hFFFFFFFF;
      @(posedge clk); #1;
      dreq[3] = 1'b1;
      rst[3]  = 1'b1;
      #1;
      check("midrst_stall", {31'd0, stall[3]}, 32'd0);
      check("midrst_dvalid", {31'd0, dvalid[3]}, 32'd0);
      check("midrst_drdata", drdata[3], 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("midrst_no_pulse_%0d", c), {31'd0, dvalid[3]}, 32'd0);
      end
      @(posedge clk); #1;
      rst[3] = 1'b0;
      @(posedge clk); #1;
      check("postrst_idle_stall", {31'd0, stall[3]}, 32'd0);
      do_access(3, 1'b0, 32'h50, 32'h0, 32'h0BADF00D);

      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", sb_q.size(), 32'd0);
      check("pulse_count", pulses, accesses);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
